// File: rtl/path_count_engine.sv
// Single-pass DAG path counter: walks children from one source through a merging
// node queue and accumulates path counts for NUM_TARGETS target nodes at once.
//
// state | meaning
// IDLE  | waiting for start; outputs hold last run's results
// INIT  | push source with count 1, seed target slots equal to the source
// POP   | take queue head into cur_node/cur_count, or finish if empty
// CHILD | request children of cur_node, fold each child beat into targets/queue
// DONE  | one-cycle completion pulse
module path_count_engine #(
  parameter int NODE_IDX_WIDTH = 10,
  parameter int ACCUM_WIDTH    = 32,
  parameter int FIFO_DEPTH     = 32,
  parameter int NUM_TARGETS    = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NODE_IDX_WIDTH-1:0]             start_node_idx,
  input  logic [NUM_TARGETS*NODE_IDX_WIDTH-1:0] target_node_idx,
  output logic                                  req_valid,
  output logic [NODE_IDX_WIDTH-1:0]             req_node_idx,
  input  logic                                  rsp_valid,
  input  logic [NODE_IDX_WIDTH-1:0]             rsp_node_idx,
  input  logic                                  rsp_last,
  input  logic                                  rsp_leaf,
  output logic                                  busy,
  output logic                                  done,
  output logic [NUM_TARGETS*ACCUM_WIDTH-1:0]    path_count,
  output logic                                  overflow,
  output logic                                  saturated
);

  localparam int W     = NODE_IDX_WIDTH;
  localparam int A     = ACCUM_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [A-1:0] CNT_MAX = '1;
  localparam logic [A-1:0] CNT_ONE = A'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_POP,
    S_CHILD,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]     src_node;
  logic [W-1:0]     tgt_node [NUM_TARGETS];
  logic [A-1:0]     tgt_cnt  [NUM_TARGETS];
  logic [W-1:0]     q_node   [FIFO_DEPTH];
  logic [A-1:0]     q_cnt    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [W-1:0]     cur_node;
  logic [A-1:0]     cur_count;
  logic             req_pend;

  logic q_full, q_empty;
  logic beat, child_beat, beat_end;
  logic any_tgt, any_q, do_merge, do_push, do_ovf, merge_clip, tgt_clip_any;
  logic [NUM_TARGETS-1:0] tgt_hit, tgt_clip;
  logic [A:0]             tgt_sum [NUM_TARGETS];
  logic [FIFO_DEPTH-1:0]  q_hit;
  logic [PTR_W-1:0]       hit_idx;
  logic [A-1:0]           hit_cnt;
  logic [A:0]             merge_sum;

  // Entries between rd_ptr and wr_ptr are always valid, so the head bit disambiguates
  assign q_full  = (wr_ptr == rd_ptr) && q_vld[rd_ptr];
  assign q_empty = (wr_ptr == rd_ptr) && !q_vld[rd_ptr];

  // Beats during the request cycle are not legal and are ignored
  assign beat       = (state == S_CHILD) && !req_pend && rsp_valid;
  assign child_beat = beat && !rsp_leaf;
  assign beat_end   = beat && (rsp_last || rsp_leaf);

  always_comb begin
    tgt_hit = '0;
    tgt_clip = '0;
    q_hit   = '0;
    hit_idx = '0;
    hit_cnt = '0;
    for (int k = 0; k < NUM_TARGETS; k++) begin
      tgt_sum[k]  = {1'b0, tgt_cnt[k]} + {1'b0, cur_count};
      tgt_clip[k] = tgt_sum[k][A];
      tgt_hit[k]  = child_beat && (rsp_node_idx == tgt_node[k]);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      q_hit[i] = q_vld[i] && (q_node[i] == rsp_node_idx);
      if (q_hit[i]) begin
        hit_idx = PTR_W'(i);
        hit_cnt = q_cnt[i];
      end
    end
    merge_sum = {1'b0, hit_cnt} + {1'b0, cur_count};
  end

  assign merge_clip   = merge_sum[A];
  assign tgt_clip_any = |(tgt_hit & tgt_clip);
  assign any_tgt      = |tgt_hit;
  assign any_q        = |q_hit;
  assign do_merge     = child_beat && !any_tgt && any_q;
  assign do_push      = child_beat && !any_tgt && !any_q && !q_full;
  assign do_ovf       = child_beat && !any_tgt && !any_q && q_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_INIT;
      S_INIT:  state_nxt = S_POP;
      S_POP:   state_nxt = q_empty ? S_DONE : S_CHILD;
      S_CHILD: begin
        if (do_ovf)        state_nxt = S_DONE;
        else if (beat_end) state_nxt = S_POP;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy         = (state == S_INIT) || (state == S_POP) || (state == S_CHILD);
  assign done         = (state == S_DONE);
  assign req_valid    = (state == S_CHILD) && req_pend;
  assign req_node_idx = cur_node;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_node  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_vld     <= '0;
      cur_node  <= '0;
      cur_count <= '0;
      req_pend  <= 1'b0;
      overflow  <= 1'b0;
      saturated <= 1'b0;
      for (int k = 0; k < NUM_TARGETS; k++) begin
        tgt_node[k] <= '0;
        tgt_cnt[k]  <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        q_node[i] <= '0;
        q_cnt[i]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_node  <= start_node_idx;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_vld     <= '0;
            overflow  <= 1'b0;
            saturated <= 1'b0;
            for (int k = 0; k < NUM_TARGETS; k++) begin
              tgt_node[k] <= target_node_idx[k*W +: W];
              tgt_cnt[k]  <= '0;
            end
          end
        end
        S_INIT: begin
          q_node[wr_ptr] <= src_node;
          q_cnt[wr_ptr]  <= CNT_ONE;
          q_vld[wr_ptr]  <= 1'b1;
          wr_ptr         <= wr_ptr + 1'b1;
          for (int k = 0; k < NUM_TARGETS; k++)
            if (tgt_node[k] == src_node) tgt_cnt[k] <= CNT_ONE;
        end
        S_POP: begin
          if (!q_empty) begin
            cur_node      <= q_node[rd_ptr];
            cur_count     <= q_cnt[rd_ptr];
            q_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
            req_pend      <= 1'b1;
          end
        end
        S_CHILD: begin
          req_pend <= 1'b0;
          for (int k = 0; k < NUM_TARGETS; k++)
            if (tgt_hit[k]) tgt_cnt[k] <= tgt_clip[k] ? CNT_MAX : tgt_sum[k][A-1:0];
          if (do_merge)
            q_cnt[hit_idx] <= merge_clip ? CNT_MAX : merge_sum[A-1:0];
          if (tgt_clip_any || (do_merge && merge_clip))
            saturated <= 1'b1;
          if (do_push) begin
            q_node[wr_ptr] <= rsp_node_idx;
            q_cnt[wr_ptr]  <= cur_count;
            q_vld[wr_ptr]  <= 1'b1;
            wr_ptr         <= wr_ptr + 1'b1;
          end
          if (do_ovf) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    path_count = '0;
    for (int k = 0; k < NUM_TARGETS; k++)
      path_count[k*A +: A] = tgt_cnt[k];
  end

endmodule

// File: tb/tb_path_count_engine.sv
// Bench for path_count_engine: a responder serves adjacency from a small graph table,
// expected requests and per-run results are queued up front and checked as the DUT emits them.
module tb_path_count_engine;

  localparam int W  = 10;
  localparam int NT = 2;
  localparam int AA = 32;
  localparam int AB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] start_node_idx = '0;
  logic [NT*W-1:0] target_node_idx = '0;
  logic rsp_valid = 1'b0;
  logic [W-1:0] rsp_node_idx = '0;
  logic rsp_last = 1'b0;
  logic rsp_leaf = 1'b0;

  logic req_valid_a, busy_a, done_a, ovf_a, sat_a;
  logic [W-1:0] req_node_a;
  logic [NT*AA-1:0] path_count_a;
  logic req_valid_b, busy_b, done_b, ovf_b, sat_b;
  logic [W-1:0] req_node_b;
  logic [NT*AB-1:0] path_count_b;

  always #5 clk = ~clk;

  path_count_engine #(.NODE_IDX_WIDTH(W), .ACCUM_WIDTH(AA), .FIFO_DEPTH(32), .NUM_TARGETS(NT)) u_dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .start_node_idx(start_node_idx),
    .target_node_idx(target_node_idx), .req_valid(req_valid_a), .req_node_idx(req_node_a),
    .rsp_valid(rsp_valid), .rsp_node_idx(rsp_node_idx), .rsp_last(rsp_last), .rsp_leaf(rsp_leaf),
    .busy(busy_a), .done(done_a), .path_count(path_count_a), .overflow(ovf_a), .saturated(sat_a));

  path_count_engine #(.NODE_IDX_WIDTH(W), .ACCUM_WIDTH(AB), .FIFO_DEPTH(4), .NUM_TARGETS(NT)) u_dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .start_node_idx(start_node_idx),
    .target_node_idx(target_node_idx), .req_valid(req_valid_b), .req_node_idx(req_node_b),
    .rsp_valid(rsp_valid), .rsp_node_idx(rsp_node_idx), .rsp_last(rsp_last), .rsp_leaf(rsp_leaf),
    .busy(busy_b), .done(done_b), .path_count(path_count_b), .overflow(ovf_b), .saturated(sat_b));

  logic req_s, busy_s, done_s, ovf_s, sat_s;
  logic [W-1:0] req_node_s;
  logic [31:0] cnt_s [NT];

  always_comb begin
    req_s      = sel ? req_valid_b : req_valid_a;
    req_node_s = sel ? req_node_b  : req_node_a;
    busy_s     = sel ? busy_b      : busy_a;
    done_s     = sel ? done_b      : done_a;
    ovf_s      = sel ? ovf_b       : ovf_a;
    sat_s      = sel ? sat_b       : sat_a;
    for (int k = 0; k < NT; k++)
      cnt_s[k] = sel ? 32'(path_count_b[k*AB +: AB]) : path_count_a[k*AA +: AA];
  end

  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    logic ovf;
    logic sat;
  } exp_t;

  exp_t exp_q[$];
  int exp_req_q[$];
  int pend_q[$];
  int kids[16][$];

  int total = 0;
  int bad = 0;
  int cyc_ctr = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_req_cyc = 0;
  int run_reqs = 0;
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_s) begin
        if (run_reqs == 0) first_req_cyc = cyc_ctr;
        run_reqs++;
        chk("req_expected", 32'(exp_req_q.size() > 0), 1);
        if (exp_req_q.size() > 0) chk("req_node", 32'(req_node_s), 32'(exp_req_q.pop_front()));
        pend_q.push_back(int'(req_node_s));
      end
      if (done_s) begin
        exp_t e;
        done_cnt++;
        done_cyc = cyc_ctr;
        chk("busy_in_done", 32'(busy_s), 0);
        chk("done_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("path_count0", cnt_s[0], e.c0);
          chk("path_count1", cnt_s[1], e.c1);
          chk("overflow", 32'(ovf_s), 32'(e.ovf));
          chk("saturated", 32'(sat_s), 32'(e.sat));
        end
      end
    end
  end

  task automatic clear_graph();
    for (int i = 0; i < 16; i++) kids[i].delete();
  endtask

  task automatic add_edge(input int p, input int c);
    kids[p].push_back(c);
  endtask

  task automatic set_merge();
    clear_graph();
    add_edge(0, 1); add_edge(0, 2); add_edge(1, 4); add_edge(2, 4); add_edge(4, 5);
  endtask

  task automatic pulse_start(input int src, input int t0, input int t1);
    run_reqs = 0;
    pend_q.delete();
    @(posedge clk); #1;
    start = 1'b1;
    start_node_idx = W'(src);
    target_node_idx = {W'(t1), W'(t0)};
    start_cyc = cyc_ctr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic serve(input string name, input int gap_max, input int budget, input int base);
    int cyc;
    int node;
    int g;
    cyc = 0;
    while (done_cnt == base && cyc < budget) begin
      if (pend_q.size() > 0) begin
        node = pend_q.pop_front();
        if (kids[node].size() == 0) begin
          rsp_valid = 1'b1; rsp_leaf = 1'b1; rsp_node_idx = '0;
          @(posedge clk); #1; cyc++;
        end else begin
          for (int i = 0; i < kids[node].size(); i++) begin
            g = $urandom_range(gap_max, 0);
            repeat (g) begin
              rsp_valid = 1'b0; rsp_last = 1'b0;
              @(posedge clk); #1; cyc++;
            end
            rsp_valid = 1'b1;
            rsp_node_idx = W'(kids[node][i]);
            rsp_last = (i == kids[node].size() - 1);
            @(posedge clk); #1; cyc++;
          end
        end
        rsp_valid = 1'b0; rsp_last = 1'b0; rsp_leaf = 1'b0;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    chk({name, "_done_count"}, 32'(done_cnt - base), 1);
  endtask

  task automatic run_test(input string name, input bit use_b, input int src, input int t0,
                          input int t1, input int gap_max, input int c0, input int c1,
                          input bit ovf, input bit sat);
    exp_t e;
    int base;
    sel = use_b;
    e.c0 = 32'(c0); e.c1 = 32'(c1); e.ovf = ovf; e.sat = sat;
    exp_q.push_back(e);
    base = done_cnt;
    pulse_start(src, t0, t1);
    chk({name, "_busy_rise"}, 32'(busy_s), 1);
    serve(name, gap_max, 3000, base);
    chk({name, "_req_left"}, 32'(exp_req_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_valid", 32'(req_valid_a), 0);
    chk("rst_req_node", 32'(req_node_a), 0);
    chk("rst_count_a", path_count_a[31:0] | path_count_a[63:32], 0);
    chk("rst_flags_a", 32'({ovf_a, sat_a}), 0);
    chk("rst_b", 32'({busy_b, done_b, req_valid_b, ovf_b, sat_b, path_count_b}), 0);

    clear_graph();
    exp_req_q = '{0};
    run_test("leaf", 1'b0, 0, 7, 8, 0, 0, 0, 1'b0, 1'b0);
    chk("leaf_req_lat", 32'(first_req_cyc - start_cyc), 3);
    chk("leaf_done_lat", 32'(done_cyc - start_cyc), 6);
    chk("leaf_req_count", 32'(run_reqs), 1);

    set_merge();
    exp_req_q = '{0, 1, 2, 4};
    run_test("merge", 1'b0, 0, 5, 6, 0, 2, 0, 1'b0, 1'b0);
    exp_req_q = '{0, 1, 2, 4};
    run_test("merge_bp", 1'b0, 0, 5, 6, 5, 2, 0, 1'b0, 1'b0);

    clear_graph();
    add_edge(0, 3);
    exp_req_q = '{0};
    run_test("dup_tgt", 1'b0, 0, 3, 3, 1, 1, 1, 1'b0, 1'b0);

    clear_graph();
    add_edge(0, 1);
    exp_req_q = '{0, 1};
    run_test("src_tgt", 1'b0, 0, 0, 9, 0, 1, 0, 1'b0, 1'b0);

    clear_graph();
    for (int c = 10; c < 16; c++) add_edge(0, c);
    exp_req_q = '{0};
    run_test("ovf", 1'b1, 0, 7, 8, 0, 0, 0, 1'b1, 1'b0);
    chk("ovf_done_lat", 32'(done_cyc - start_cyc), 9);
    repeat (2) begin
      rsp_valid = 1'b1; rsp_node_idx = W'(7); rsp_last = 1'b1;
      @(posedge clk); #1;
    end
    rsp_valid = 1'b0; rsp_last = 1'b0;
    chk("ovf_ignore_cnt", cnt_s[0], 0);
    chk("ovf_sticky", 32'(ovf_s), 1);
    chk("ovf_idle", 32'(busy_s), 0);

    clear_graph();
    add_edge(0, 1); add_edge(0, 2);
    add_edge(1, 3); add_edge(1, 4);
    add_edge(2, 3); add_edge(2, 4);
    add_edge(3, 9); add_edge(4, 9);
    exp_req_q = '{0, 1, 2, 3, 4};
    run_test("sat", 1'b1, 0, 9, 8, 1, 3, 0, 1'b0, 1'b1);

    set_merge();
    exp_req_q = '{0, 1, 2, 4};
    run_test("merge_b", 1'b1, 0, 5, 6, 2, 2, 0, 1'b0, 1'b0);

    sel = 1'b0;
    clear_graph();
    add_edge(0, 1);
    exp_req_q = '{0};
    base = done_cnt;
    pulse_start(0, 0, 9);
    n = 0;
    while (pend_q.size() == 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("rst_mid_req_seen", 32'(pend_q.size()), 1);
    chk("rst_mid_pre_cnt", cnt_s[0], 1);
    chk("rst_mid_pre_busy", 32'(busy_s), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy_s), 0);
    chk("rst_mid_cnt", cnt_s[0], 0);
    chk("rst_mid_req", 32'(req_s), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_no_done", 32'(done_cnt - base), 0);
    rst = 1'b0;
    pend_q.delete();

    clear_graph();
    exp_req_q = '{0};
    run_test("after_rst", 1'b0, 0, 7, 8, 0, 0, 0, 1'b0, 1'b0);
    chk("after_rst_done_lat", 32'(done_cyc - start_cyc), 6);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
